register_file_sb: RTL and testbench

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/register_file_sb.sv | 169 ++++++++++++++++
 tb/tb_register_file_sb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// Integer register file with per-register busy (scoreboard) bits for in-order issue.
// A sequential clear sweep runs after every reset before the file reports ready.
module register_file_sb #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   parameter  int NRD  = 2,
   localparam int AW   = $clog2(NREG),
   localparam int CW   = $clog2(NREG + 1)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                ready,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic                iss_stall,
   output logic [CW-1:0]       busy_cnt
);

   typedef enum logic {INIT, READY} state_e;

   state_e              state_q, state_d;
   logic [AW-1:0]       ptr_q, ptr_d;
   logic [XLEN-1:0]     regs_q [NREG];
   logic [NREG-1:0]     busy_q, busy_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic                wr_fire;
   logic                iss_acc;
   logic                cnt_inc;
   logic                cnt_dec;

   // ---------------------------------------------------------------
   // Init/ready sequencer
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         INIT: begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(NREG - 1)) begin
               state_d = READY;
               ptr_d   = '0;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = INIT;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign ready = (state_q == READY);

   // ---------------------------------------------------------------
   // Write / issue qualification
   // ---------------------------------------------------------------
   assign wr_fire = ready && wr_en && (wr_addr != '0);

   // A pending destination may be re-claimed only on the edge its writeback lands.
   assign iss_stall = !ready ||
                      (iss_en && (iss_addr != '0) && busy_q[iss_addr] &&
                       !(wr_en && (wr_addr == iss_addr)));

   assign iss_acc = iss_en && !iss_stall && (iss_addr != '0);

   assign cnt_dec = wr_fire && busy_q[wr_addr];
   assign cnt_inc = iss_acc &&
                    (!busy_q[iss_addr] || (wr_fire && (wr_addr == iss_addr)));

   // ---------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (state_q == INIT) begin
         busy_d[ptr_q] = 1'b0;
      end else begin
         if (wr_fire) begin
            busy_d[wr_addr] = 1'b0;
         end
         if (iss_acc) begin
            busy_d[iss_addr] = 1'b1;
         end
         cnt_d = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_cnt = cnt_q;

   // ---------------------------------------------------------------
   // Register storage: the INIT sweep is the only reset it gets
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         regs_q[ptr_q] <= '0;
      end else if (wr_fire && !rst) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   // ---------------------------------------------------------------
   // Read ports: write-first bypass, x0 and INIT read as zero
   // ---------------------------------------------------------------
   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data_d, data_q;
      logic            busy_bit_d, busy_bit_q;

      assign addr = rd_addr[gi*AW +: AW];

      always_comb begin
         data_d     = '0;
         busy_bit_d = 1'b0;
         if (ready && (addr != '0)) begin
            if (wr_fire && (wr_addr == addr)) begin
               data_d = wr_data;
            end else begin
               data_d = regs_q[addr];
            end
            busy_bit_d = busy_d[addr];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            data_q     <= '0;
            busy_bit_q <= 1'b0;
         end else begin
            data_q     <= data_d;
            busy_bit_q <= busy_bit_d;
         end
      end

      assign rd_data[gi*XLEN +: XLEN] = data_q;
      assign rd_busy[gi]              = busy_bit_q;
   end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: init sweep, bypass, scoreboard and reset restart.
// Expected values are hand-derived constants checked with immediate assertions.
module tb_register_file_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;
   localparam int CW   = 6;

   logic                clk = 1'b0;
   logic                rst;
   logic                ready;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic                iss_stall;
   logic [CW-1:0]       busy_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   register_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
      .clk       (clk),
      .rst       (rst),
      .ready     (ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .iss_en    (iss_en),
      .iss_addr  (iss_addr),
      .iss_stall (iss_stall),
      .busy_cnt  (busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic idle();
      wr_en = 1'b0; iss_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0; rd_addr = '0;

      // Reset and init sweep
      tick();
      rst = 1'b0;
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_cnt", 64'(busy_cnt), 64'd0);
      chk("rst_rdata", 64'(rd_data), 64'd0);
      chk("rst_rbusy", 64'(rd_busy), 64'd0);
      chk("init_stall", 64'(iss_stall), 64'd1);
      for (int c = 1; c <= NREG; c++) begin
         tick();
         chk($sformatf("init_ready_c%0d", c), 64'(ready), 64'(c >= NREG));
      end
      for (int a = 0; a < NREG; a += 2) begin
         set_rd(AW'(a), AW'(a + 1));
         tick();
         chk($sformatf("zero_rd_x%0d", a), 64'(rd_data), 64'd0);
         chk($sformatf("zero_busy_x%0d", a), 64'(rd_busy), 64'd0);
      end

      // Write-first bypass and hardwired x0
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; set_rd(5'd5, 5'd0);
      tick(); idle();
      chk("bypass_x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
      chk("bypass_x0_lane1", 64'(rd_data[63:32]), 64'd0);
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; set_rd(5'd0, 5'd5);
      tick(); idle();
      chk("x0_write_bypass", 64'(rd_data[31:0]), 64'd0);
      chk("x5_held", 64'(rd_data[63:32]), 64'hDEADBEEF);
      tick();
      chk("x0_write_stored", 64'(rd_data[31:0]), 64'd0);
      chk("x0_cnt", 64'(busy_cnt), 64'd0);

      // Issue x7, refused re-issue, writeback clears
      set_rd(5'd7, 5'd0);
      iss_en = 1'b1; iss_addr = 5'd7; #1;
      chk("iss7_stall", 64'(iss_stall), 64'd0);
      tick(); idle();
      chk("iss7_cnt", 64'(busy_cnt), 64'd1);
      chk("iss7_busy", 64'(rd_busy), 64'b01);
      iss_en = 1'b1; iss_addr = 5'd7; #1;
      chk("reiss7_stall", 64'(iss_stall), 64'd1);
      tick(); idle();
      chk("reiss7_cnt", 64'(busy_cnt), 64'd1);
      iss_en = 1'b1; iss_addr = 5'd0; #1;
      chk("iss0_stall", 64'(iss_stall), 64'd0);
      tick(); idle();
      chk("iss0_cnt", 64'(busy_cnt), 64'd1);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
      tick(); idle();
      chk("wb7_busy", 64'(rd_busy), 64'b00);
      chk("wb7_cnt", 64'(busy_cnt), 64'd0);
      chk("wb7_data", 64'(rd_data[31:0]), 64'h55);

      // Write and issue same busy register
      set_rd(5'd9, 5'd7);
      iss_en = 1'b1; iss_addr = 5'd9;
      tick(); idle();
      chk("iss9_cnt", 64'(busy_cnt), 64'd1);
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5;
      iss_en = 1'b1; iss_addr = 5'd9; #1;
      chk("wi9_stall", 64'(iss_stall), 64'd0);
      tick(); idle();
      chk("wi9_data", 64'(rd_data[31:0]), 64'hA5);
      chk("wi9_busy", 64'(rd_busy), 64'b01);
      chk("wi9_cnt", 64'(busy_cnt), 64'd1);

      // Writeback of x9 while issuing x10: count nets out
      set_rd(5'd9, 5'd10);
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9;
      iss_en = 1'b1; iss_addr = 5'd10;
      tick(); idle();
      chk("mix_busy", 64'(rd_busy), 64'b10);
      chk("mix_cnt", 64'(busy_cnt), 64'd1);
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h10;
      tick(); idle();
      chk("wb10_cnt", 64'(busy_cnt), 64'd0);
      chk("wb10_data", 64'(rd_data[63:32]), 64'h10);

      // Coinciding read ports
      set_rd(5'd12, 5'd12);
      wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0F0F0F0F;
      tick(); idle();
      chk("dual12_bypass", 64'(rd_data), 64'h0F0F0F0F_0F0F0F0F);
      tick();
      chk("dual12_stored", 64'(rd_data), 64'h0F0F0F0F_0F0F0F0F);

      // Reset mid-operation, then again partway through INIT
      iss_en = 1'b1; iss_addr = 5'd3;
      tick();
      iss_addr = 5'd4;
      tick(); idle();
      chk("iss34_cnt", 64'(busy_cnt), 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_cnt", 64'(busy_cnt), 64'd0);
      chk("rst2_ready", 64'(ready), 64'd0);
      set_rd(5'd5, 5'd12);
      wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hBAD;
      iss_en = 1'b1; iss_addr = 5'd21;
      for (int c = 1; c <= 10; c++) begin
         tick();
         chk($sformatf("init2_ready_c%0d", c), 64'(ready), 64'd0);
      end
      chk("init2_rdata", 64'(rd_data), 64'd0);
      chk("init2_cnt", 64'(busy_cnt), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 1; c <= NREG; c++) begin
         if (c == NREG) idle();
         tick();
         chk($sformatf("init3_ready_c%0d", c), 64'(ready), 64'(c >= NREG));
      end
      idle();
      chk("init3_cnt", 64'(busy_cnt), 64'd0);
      set_rd(5'd3, 5'd4);
      tick();
      chk("post_x3x4_data", 64'(rd_data), 64'd0);
      chk("post_x3x4_busy", 64'(rd_busy), 64'b00);
      set_rd(5'd20, 5'd21);
      tick();
      chk("post_x20x21_data", 64'(rd_data), 64'd0);
      chk("post_x20x21_busy", 64'(rd_busy), 64'b00);
      set_rd(5'd5, 5'd12);
      tick();
      chk("post_x5x12_data", 64'(rd_data), 64'd0);
      chk("post_cnt", 64'(busy_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
